// File: rtl/conv33_pkg.sv
// Shared constants for the conv33 window generator and the benches that drive it.
// window_count gives the number of valid (unpadded) 3x3 windows in a frame.
package conv33_pkg;

    localparam int DEF_DATA_WIDTH = 32'sd8;
    localparam int DEF_IMG_W      = 32'sd28;
    localparam int DEF_IMG_H      = 32'sd28;

    function automatic int window_count(input int img_w, input int img_h);
        return (img_w - 32'sd2) * (img_h - 32'sd2);
    endfunction

    localparam int NUM_WINDOWS = window_count(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/conv33_line_buf.sv
// Single-line delay: a circular RAM whose read happens before the write at the same slot,
// so dout is the sample written DEPTH enables earlier.
module conv33_line_buf #(
    parameter int DATA_WIDTH = 32'sd8,
    parameter int DEPTH      = 32'sd28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int PW = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 32'sd1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         ptr_r;

    // Oldest sample sits at the slot about to be overwritten.
    always_comb begin
        dout = mem_r[ptr_r];
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_r[ptr_r] <= din;
        end
    end

    // Wrapping write/read pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= PTR_ZERO;
        end else if (en) begin
            if (ptr_r == PTR_LAST) begin
                ptr_r <= PTR_ZERO;
            end else begin
                ptr_r <= ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/conv33_window.sv
// Streaming 3x3 sliding-window generator: two chained line delays feed a 3x3 tap array,
// and conv33_en flags only windows lying fully inside the current frame.
module conv33_window
    import conv33_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] pix_in,
    input  logic                         pix_valid,
    output logic signed [DATA_WIDTH-1:0] data_0_0,
    output logic signed [DATA_WIDTH-1:0] data_0_1,
    output logic signed [DATA_WIDTH-1:0] data_0_2,
    output logic signed [DATA_WIDTH-1:0] data_1_0,
    output logic signed [DATA_WIDTH-1:0] data_1_1,
    output logic signed [DATA_WIDTH-1:0] data_1_2,
    output logic signed [DATA_WIDTH-1:0] data_2_0,
    output logic signed [DATA_WIDTH-1:0] data_2_1,
    output logic signed [DATA_WIDTH-1:0] data_2_2,
    output logic                         conv33_en,
    output logic                         frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 32'sd1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 32'sd1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2'd2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2'd2);
    localparam logic [CW-1:0] COL_ONE  = CW'(1'b1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1'b1);
    localparam logic [CW-1:0] COL_ZERO = CW'(1'b0);
    localparam logic [RW-1:0] ROW_ZERO = RW'(1'b0);
    localparam logic signed [DATA_WIDTH-1:0] PIX_ZERO = DATA_WIDTH'(1'b0);

    logic [CW-1:0]                col_cnt_r;
    logic [RW-1:0]                row_cnt_r;
    logic [DATA_WIDTH-1:0]        lb1_out_s;
    logic [DATA_WIDTH-1:0]        lb2_out_s;
    logic signed [DATA_WIDTH-1:0] tap_r [3][3];
    logic                         conv33_en_r;
    logic                         frame_done_r;
    logic                         col_last_s;
    logic                         row_last_s;
    logic                         win_ok_s;
    logic                         frame_end_s;

    conv33_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W)
    ) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_valid),
        .din  (pix_in),
        .dout (lb1_out_s)
    );

    conv33_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W)
    ) u_lb2 (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_valid),
        .din  (lb1_out_s),
        .dout (lb2_out_s)
    );

    // Position decode for the pixel currently on pix_in.
    always_comb begin
        col_last_s  = (col_cnt_r == COL_LAST);
        row_last_s  = (row_cnt_r == ROW_LAST);
        win_ok_s    = (col_cnt_r >= COL_TWO) && (row_cnt_r >= ROW_TWO);
        frame_end_s = col_last_s && row_last_s;
    end

    // Raster position counters; wrap at end of frame with no idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_r <= COL_ZERO;
            row_cnt_r <= ROW_ZERO;
        end else if (pix_valid) begin
            if (col_last_s) begin
                col_cnt_r <= COL_ZERO;
                if (row_last_s) begin
                    row_cnt_r <= ROW_ZERO;
                end else begin
                    row_cnt_r <= row_cnt_r + ROW_ONE;
                end
            end else begin
                col_cnt_r <= col_cnt_r + COL_ONE;
            end
        end
    end

    // Tap array: columns shift left, new column enters from the line delays and pix_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    tap_r[r][c] <= PIX_ZERO;
                end
            end
        end else if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                tap_r[r][0] <= tap_r[r][1];
                tap_r[r][1] <= tap_r[r][2];
            end
            tap_r[0][2] <= lb2_out_s;
            tap_r[1][2] <= lb1_out_s;
            tap_r[2][2] <= pix_in;
        end
    end

    // Window qualifiers; only a fully in-frame window is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv33_en_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            conv33_en_r  <= pix_valid && win_ok_s;
            frame_done_r <= pix_valid && win_ok_s && frame_end_s;
        end
    end

    assign data_0_0   = tap_r[0][0];
    assign data_0_1   = tap_r[0][1];
    assign data_0_2   = tap_r[0][2];
    assign data_1_0   = tap_r[1][0];
    assign data_1_1   = tap_r[1][1];
    assign data_1_2   = tap_r[1][2];
    assign data_2_0   = tap_r[2][0];
    assign data_2_1   = tap_r[2][1];
    assign data_2_2   = tap_r[2][2];
    assign conv33_en  = conv33_en_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_conv33_window.sv
// Scoreboard bench for conv33_window on a 5x5 image: the driver records each frame as a
// 2-D image and queues the expected 3x3 window; a negedge monitor pops and compares.
module tb_conv33_window;
    import conv33_pkg::*;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 5;

    typedef struct packed {
        logic [9*DW-1:0] taps;
        logic            fd;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] pix_in;
    logic                 pix_valid;
    logic signed [DW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
    logic                 conv33_en;
    logic                 frame_done;

    conv33_window #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .data_0_0   (d00), .data_0_1 (d01), .data_0_2 (d02),
        .data_1_0   (d10), .data_1_1 (d11), .data_1_2 (d12),
        .data_2_0   (d20), .data_2_1 (d21), .data_2_2 (d22),
        .conv33_en  (conv33_en),
        .frame_done (frame_done)
    );

    int   checks   = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    exp_t exp_q[$];
    logic [DW-1:0] img [H][W];
    int   cur_r = 0;
    int   cur_c = 0;
    logic acc_at_edge = 1'b0;
    logic rst_at_edge = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the DUT saw at the last rising edge.
    always @(posedge clk) begin
        acc_at_edge = pix_valid && !rst;
        rst_at_edge = rst;
    end

    // Monitor: compares every flagged window against the scoreboard.
    always @(negedge clk) begin
        logic [9*DW-1:0] got;
        exp_t e;
        got = {d00, d01, d02, d10, d11, d12, d20, d21, d22};
        if (rst_at_edge) begin
            checks++;
            if (got != '0 || conv33_en !== 1'b0 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs got taps=%h en=%b fd=%b required all 0", got, conv33_en, frame_done);
            end
        end else if (conv33_en === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (!acc_at_edge) begin
                failures++;
                $display("FAIL en_in_gap got conv33_en=1 required 0 (no pixel accepted)");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window got taps=%h required no window", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.taps) begin
                    failures++;
                    $display("FAIL window got taps=%h required %h", got, e.taps);
                end
                checks++;
                if (frame_done !== e.fd) begin
                    failures++;
                    $display("FAIL frame_done got %b required %b", frame_done, e.fd);
                end
            end
        end else if (frame_done !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL frame_done_alone got %b required 0", frame_done);
        end
    end

    // Drive one pixel for one accepted cycle and record the window it completes.
    task automatic send(input logic signed [DW-1:0] p);
        exp_t e;
        img[cur_r][cur_c] = p;
        if (cur_r >= 2 && cur_c >= 2) begin
            e.taps = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    e.taps = {e.taps[8*DW-1:0], img[cur_r-2+i][cur_c-2+j]};
                end
            end
            e.fd = (cur_r == H-1) && (cur_c == W-1);
            exp_q.push_back(e);
        end
        pix_in    = p;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_in    = $urandom_range(0, 255);
        cur_c++;
        if (cur_c == W) begin
            cur_c = 0;
            cur_r = (cur_r == H-1) ? 0 : cur_r + 1;
        end
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic end_phase(input string name, input int start, input int expect_pulses);
        idle(3);
        checks++;
        if (pulse_cnt - start != expect_pulses) begin
            failures++;
            $display("FAIL %s_pulses got %0d required %0d", name, pulse_cnt - start, expect_pulses);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got %0d unmatched windows required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got timeout required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Frame 0..24 back-to-back
        start = pulse_cnt;
        for (int k = 0; k < 25; k++) send(DW'(k));
        end_phase("basic", start, window_count(W, H));

        // Same frame with random gaps
        start = pulse_cnt;
        for (int k = 0; k < 25; k++) begin
            send(DW'(k));
            idle($urandom_range(0, 3));
        end
        end_phase("gaps", start, window_count(W, H));

        // Two frames back-to-back
        start = pulse_cnt;
        for (int k = 0; k < 25; k++) send(DW'(k));
        for (int k = 0; k < 25; k++) send(DW'(100 + k));
        end_phase("two_frames", start, 2 * window_count(W, H));

        // Reset after pixel 17, then a fresh frame
        start = pulse_cnt;
        for (int k = 0; k < 18; k++) send(DW'(k));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        cur_r = 0;
        cur_c = 0;
        idle(1);
        for (int k = 0; k < 25; k++) send(DW'(k));
        end_phase("midreset", start, 4 + window_count(W, H));

        // Signed extremes with occasional random gaps
        start = pulse_cnt;
        for (int k = 0; k < 25; k++) begin
            send((k % 2) ? 8'sd127 : -8'sd128);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        end_phase("signed", start, window_count(W, H));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
